// File: rtl/hold_ctrl.sv
// ============================================================================
// hold_ctrl : pipeline hazard/hold controller with external data-RAM grant
// Rev 1.0
// ============================================================================
`default_nettype none

module hold_ctrl #(
  parameter int RUN_MIN = 4,
  parameter int CNT_W   = 32
) (
  input  logic             i_Clk,
  input  logic             i_reset,
  input  logic [1:0]       i_hold_type,
  input  logic             i_jump_flag,
  input  logic [31:0]      i_jump_addr,
  input  logic             i_ext_req,
  output logic             o_jump_flag,
  output logic [31:0]      o_jump_addr,
  output logic             o_hold_pc,
  output logic             o_hold_if_id,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_ext_ack,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int              RC_W      = (RUN_MIN > 0) ? $clog2(RUN_MIN + 1) : 1;
  localparam logic [RC_W-1:0] c_run_min = RC_W'(RUN_MIN);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  state_t           r_state;
  logic [RC_W-1:0]  r_run_cnt;
  logic             r_ext_ack;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_jump_flag;
  logic [31:0]      w_jump_addr;
  logic             w_hold_pc;
  logic             w_hold_if_id;
  logic             w_flush_if_id;
  logic             w_flush_id_ex;
  logic             w_grant;

  // Branch beats load; HOLD and RESUME both freeze the front of the pipe.
  always_comb begin
    w_jump_flag   = 1'b0;
    w_jump_addr   = 32'd0;
    w_hold_pc     = 1'b0;
    w_hold_if_id  = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    if (!i_reset) begin
      if (r_state == ST_RUN) begin
        if (i_hold_type[0] || i_jump_flag) begin
          w_jump_flag   = 1'b1;
          w_jump_addr   = i_jump_addr;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (i_hold_type[1]) begin
          w_hold_pc     = 1'b1;
          w_hold_if_id  = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end else begin
        w_hold_pc     = 1'b1;
        w_hold_if_id  = 1'b1;
        w_flush_id_ex = 1'b1;
      end
    end
  end

  assign w_grant = (r_state == ST_RUN) && i_ext_req && (i_hold_type == 2'b00) &&
                   !i_jump_flag && (r_run_cnt >= c_run_min);

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_state   <= ST_RUN;
      r_run_cnt <= c_run_min;
      r_ext_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_run_cnt < c_run_min) begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
          if (w_grant) begin
            r_state   <= ST_HOLD;
            r_ext_ack <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!i_ext_req) begin
            r_state   <= ST_RESUME;
            r_ext_ack <= 1'b0;
          end
        end
        ST_RESUME: begin
          // Restart the anti-starvation window so the core gets RUN_MIN cycles.
          r_state   <= ST_RUN;
          r_run_cnt <= '0;
        end
        default: begin
          r_state   <= ST_RUN;
          r_ext_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_hold_pc) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_jump_flag   = w_jump_flag;
  assign o_jump_addr   = w_jump_addr;
  assign o_hold_pc     = w_hold_pc;
  assign o_hold_if_id  = w_hold_if_id;
  assign o_flush_if_id = w_flush_if_id;
  assign o_flush_id_ex = w_flush_id_ex;
  assign o_ext_ack     = r_ext_ack;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire
